// File: rtl/mips_run_ctrl_if.sv
// rtl/mips_run_ctrl_if.sv - run controller bus; optional halt_pc/pc_match under RUN_CTRL_PC_MATCH_EN
interface mips_run_ctrl_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             core_reset;
  logic             running;
  logic             done;
  logic             halted;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;
  logic [PC_W-1:0]  final_pc;
`ifdef RUN_CTRL_PC_MATCH_EN
  logic [PC_W-1:0]  halt_pc;
  logic             pc_match;

  modport master (
    input  start, pc, halt_pc,
    output core_reset, running, done, halted, timeout, cycle_count, final_pc, pc_match
  );
  modport slave (
    output start, pc, halt_pc,
    input  core_reset, running, done, halted, timeout, cycle_count, final_pc, pc_match
  );
`else
  modport master (
    input  start, pc,
    output core_reset, running, done, halted, timeout, cycle_count, final_pc
  );
  modport slave (
    output start, pc,
    input  core_reset, running, done, halted, timeout, cycle_count, final_pc
  );
`endif
endinterface

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - core reset sequencer, bounded run, stable-PC halt detect; RUN_CTRL_PC_MATCH_EN adds halt_pc match
module mips_run_ctrl #(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 10,
  parameter int HALT_WINDOW  = 2
) (
  input  logic           clk,
  input  logic           reset,
  mips_run_ctrl_if.master bus
);
  localparam int SW = $clog2(HALT_WINDOW + 1);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYCLES);
  localparam logic [SW-1:0]    HALT_C    = SW'(HALT_WINDOW);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [SW-1:0]    stable_cnt;
  logic [PC_W-1:0]  pc_prev;
  logic             prev_valid;

  logic [CNT_W-1:0] cnt_nxt;
  logic [SW-1:0]    stable_nxt;
  logic             halt_hit;
  logic             to_hit;
  logic             match_hit;

  // Terminating conditions evaluated against the PC sampled on this RUN edge
  always_comb begin
    cnt_nxt    = bus.cycle_count + CNT_W'(1);
    stable_nxt = '0;
    if (prev_valid && (bus.pc == pc_prev))
      stable_nxt = (stable_cnt == HALT_C) ? stable_cnt : stable_cnt + SW'(1);
    halt_hit = (stable_nxt == HALT_C);
    to_hit   = (cnt_nxt == MAX_C);
`ifdef RUN_CTRL_PC_MATCH_EN
    match_hit = (bus.pc == bus.halt_pc);
`else
    match_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      hold_cnt        <= '0;
      stable_cnt      <= '0;
      pc_prev         <= '0;
      prev_valid      <= 1'b0;
      bus.core_reset  <= 1'b1;
      bus.running     <= 1'b0;
      bus.done        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.timeout     <= 1'b0;
      bus.cycle_count <= '0;
      bus.final_pc    <= '0;
`ifdef RUN_CTRL_PC_MATCH_EN
      bus.pc_match    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state      <= RESET_HOLD;
            hold_cnt   <= '0;
            bus.done   <= 1'b0;
            bus.halted <= 1'b0;
            bus.timeout <= 1'b0;
`ifdef RUN_CTRL_PC_MATCH_EN
            bus.pc_match <= 1'b0;
`endif
          end
        end
        RESET_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state           <= RUN;
            bus.core_reset  <= 1'b0;
            bus.running     <= 1'b1;
            bus.cycle_count <= '0;
            stable_cnt      <= '0;
            prev_valid      <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          bus.cycle_count <= cnt_nxt;
          pc_prev         <= bus.pc;
          prev_valid      <= 1'b1;
          stable_cnt      <= stable_nxt;
          // Halt (stable or match) outranks the cycle budget on a shared edge
          if (halt_hit || match_hit || to_hit) begin
            state          <= DONE;
            bus.core_reset <= 1'b1;
            bus.running    <= 1'b0;
            bus.done       <= 1'b1;
            bus.halted     <= halt_hit | match_hit;
            bus.timeout    <= to_hit & ~(halt_hit | match_hit);
            bus.final_pc   <= bus.pc;
`ifdef RUN_CTRL_PC_MATCH_EN
            bus.pc_match   <= match_hit;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - scoreboard bench for mips_run_ctrl
module tb_mips_run_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_run_ctrl_if #(.PC_W(32), .CNT_W(16)) bus0 ();
  mips_run_ctrl_if #(.PC_W(32), .CNT_W(16)) bus1 ();

  mips_run_ctrl #(.MAX_CYCLES(10)) u0 (.clk(clk), .reset(reset), .bus(bus0.master));
  mips_run_ctrl #(.MAX_CYCLES(4))  u1 (.clk(clk), .reset(reset), .bus(bus1.master));

  logic [31:0] pc;
  assign bus0.pc = pc;
  assign bus1.pc = pc;
`ifdef RUN_CTRL_PC_MATCH_EN
  logic [31:0] halt_pc;
  assign bus0.halt_pc = halt_pc;
  assign bus1.halt_pc = halt_pc;
  wire m0 = bus0.pc_match;
  wire m1 = bus1.pc_match;
`else
  wire m0 = 1'b0;
  wire m1 = 1'b0;
`endif

  int sel;
  wire running_s = (sel == 1) ? bus1.running : bus0.running;
  wire done_s    = (sel == 1) ? bus1.done    : bus0.done;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    logic        h;
    logic        t;
    logic        m;
    logic [15:0] cnt;
    logic [31:0] fpc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] pat [0:15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: scores each rising done against the oldest queued expectation
  int   low [2];
  logic dq  [2];

  task automatic mon(input int s, input logic cr, input logic dn, input logic h, input logic t,
                     input logic m, input logic [15:0] cnt, input logic [31:0] fpc);
    exp_t e;
    if (!cr) low[s]++;
    if (dn && !dq[s]) begin
      if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
        n_run++;
        n_fail++;
        $display("FAIL u%0d unexpected done: got done=1 required no run pending", s);
      end else begin
        e = (s == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("u%0d halted", s), 32'(h), 32'(e.h));
        check($sformatf("u%0d timeout", s), 32'(t), 32'(e.t));
        check($sformatf("u%0d cycle_count", s), 32'(cnt), 32'(e.cnt));
        check($sformatf("u%0d final_pc", s), fpc, e.fpc);
        check($sformatf("u%0d core_reset low cycles", s), 32'(low[s]), 32'(e.cnt));
`ifdef RUN_CTRL_PC_MATCH_EN
        check($sformatf("u%0d pc_match", s), 32'(m), 32'(e.m));
`endif
      end
      low[s] = 0;
    end
    dq[s] = dn;
  endtask

  initial begin
    low[0] = 0; low[1] = 0; dq[0] = 1'b0; dq[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        low[0] = 0; low[1] = 0; dq[0] = 1'b0; dq[1] = 1'b0;
      end else begin
        mon(0, bus0.core_reset, bus0.done, bus0.halted, bus0.timeout, m0, bus0.cycle_count, bus0.final_pc);
        mon(1, bus1.core_reset, bus1.done, bus1.halted, bus1.timeout, m1, bus1.cycle_count, bus1.final_pc);
      end
    end
  end

  task automatic fill_steps(input int n);
    for (int i = 0; i < 16; i++) pat[i] = 32'(4 * ((i < n) ? i : n - 1));
  endtask

  task automatic expect_run(input int s, input logic h, input logic t, input logic m,
                            input logic [15:0] cnt, input logic [31:0] fpc);
    exp_t e;
    e.h = h; e.t = t; e.m = m; e.cnt = cnt; e.fpc = fpc;
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic issue_start(input int s, input bit keep);
    sel = s;
    @(posedge clk); #1;
    if (s == 0) bus0.start = 1'b1; else bus1.start = 1'b1;
    @(posedge clk); #1;
    if (!keep) begin
      bus0.start = 1'b0;
      bus1.start = 1'b0;
    end
  endtask

  // Feeds pat[] one value per RUN edge until done or the edge budget runs out
  task automatic drive(input int max_edges, input bit expect_done);
    int w;
    int k;
    w = 0;
    while (!running_s && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    check("reset hold cycles", 32'(w), 32'd1);
    k = 0;
    while (!done_s && k < max_edges) begin
      pc = pat[(k < 16) ? k : 15];
      @(posedge clk); #1;
      k++;
    end
    if (expect_done && !done_s) begin
      n_run++;
      n_fail++;
      $display("FAIL run end: got done=0 after %0d edges required done=1", k);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " core_reset"}, 32'(bus0.core_reset), 32'd1);
    check({tag, " running"}, 32'(bus0.running), 32'd0);
    check({tag, " done"}, 32'(bus0.done), 32'd0);
    check({tag, " halted"}, 32'(bus0.halted), 32'd0);
    check({tag, " timeout"}, 32'(bus0.timeout), 32'd0);
    check({tag, " cycle_count"}, 32'(bus0.cycle_count), 32'd0);
    check({tag, " final_pc"}, bus0.final_pc, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global time limit: simulation still running, required finish");
    $fatal(1, "time limit");
  end

  initial begin
    pc = '0;
    sel = 0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
`ifdef RUN_CTRL_PC_MATCH_EN
    halt_pc = 32'hDEAD_0000;
`endif
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check("reset u1 core_reset", 32'(bus1.core_reset), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Free-running PC: budget expires after 10 RUN cycles
    fill_steps(16);
    expect_run(0, 1'b0, 1'b1, 1'b0, 16'd10, 32'd36);
    issue_start(0, 1'b0);
    check("hold core_reset", 32'(bus0.core_reset), 32'd1);
    drive(20, 1'b1);

    // PC 0,4,8,8,8: halt on second repeat
    fill_steps(3);
    expect_run(0, 1'b1, 1'b0, 1'b0, 16'd5, 32'd8);
    issue_start(0, 1'b0);
    drive(20, 1'b1);

    // MAX_CYCLES=4, PC 0,4,4,4: halt and budget coincide, halt wins
    fill_steps(2);
    expect_run(1, 1'b1, 1'b0, 1'b0, 16'd4, 32'd4);
    issue_start(1, 1'b0);
    drive(20, 1'b1);

    fill_steps(16);
    expect_run(1, 1'b0, 1'b1, 1'b0, 16'd4, 32'd12);
    issue_start(1, 1'b0);
    drive(20, 1'b1);

    // Reset mid-run after three RUN cycles
    fill_steps(16);
    issue_start(0, 1'b0);
    drive(3, 1'b0);
    check("pre-reset running", 32'(bus0.running), 32'd1);
    reset = 1'b1;
    #1;
    check_idle_outputs("midrun reset");
    @(posedge clk); #1;
    reset = 1'b0;
    expect_run(0, 1'b0, 1'b1, 1'b0, 16'd10, 32'd36);
    issue_start(0, 1'b0);
    drive(20, 1'b1);

    // start held high across DONE: back-to-back runs
    fill_steps(3);
    expect_run(0, 1'b1, 1'b0, 1'b0, 16'd5, 32'd8);
    issue_start(0, 1'b0);
    drive(20, 1'b1);
    expect_run(0, 1'b1, 1'b0, 1'b0, 16'd5, 32'd8);
    issue_start(0, 1'b1);
    check("restart done", 32'(bus0.done), 32'd0);
    check("restart halted", 32'(bus0.halted), 32'd0);
    check("restart timeout", 32'(bus0.timeout), 32'd0);
    check("restart core_reset", 32'(bus0.core_reset), 32'd1);
    drive(20, 1'b1);
    bus0.start = 1'b0;

`ifdef RUN_CTRL_PC_MATCH_EN
    halt_pc = 32'h0000_000C;
    fill_steps(16);
    expect_run(0, 1'b1, 1'b0, 1'b1, 16'd4, 32'h0C);
    issue_start(0, 1'b0);
    drive(20, 1'b1);
    halt_pc = 32'hDEAD_0000;
`endif

    repeat (3) @(negedge clk);
    check("u0 pending expectations", 32'(q0.size()), 32'd0);
    check("u1 pending expectations", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
